tone_detector: RTL and testbench

//  Receive side of the square-wave sound output: measures the period of an incoming
//  1-bit audio tone, flags tone present/absent, classifies it as one of 8 notes C4..C5.

---
 rtl/tone_detector_pkg.sv | 33 +++
 rtl/tone_detector_note_classifier.sv | 26 ++
 rtl/tone_detector.sv | 157 +++++++++++++++
 tb/tb_tone_detector.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_detector_pkg.sv
// rtl/tone_detector_pkg.sv - shared constants and helpers for the tone detector
// Purpose: note nominal periods at 50 MHz, the "no note" code, FSM encodings and
//          the window-match rule shared by the top and the note classifier.
// Ports:   none (package)
package tone_detector_pkg;

  localparam logic [3:0] NOTE_NONE  = 4'hF;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  // Nominal period of C4,D4,E4,F4,G4,A4,B4,C5 in 50 MHz clock cycles.
  function automatic int unsigned note_nom(input logic [2:0] idx);
    case (idx)
      3'd0:    return 191113;
      3'd1:    return 170265;
      3'd2:    return 151686;
      3'd3:    return 143173;
      3'd4:    return 127551;
      3'd5:    return 113636;
      3'd6:    return 101238;
      default: return 95556;
    endcase
  endfunction

  // A period belongs to a note when it is within nom/64 (~1.6%) of the nominal.
  function automatic logic note_match(input int unsigned p, input int unsigned nom);
    int unsigned diff;
    diff = (p >= nom) ? (p - nom) : (nom - p);
    return diff <= (nom >> 6);
  endfunction

endpackage

// File: rtl/tone_detector_note_classifier.sv
// rtl/tone_detector_note_classifier.sv - period to note window compare
// Purpose: combinational lookup of which C4..C5 window contains a period;
//          NOTE_NONE when no window matches.
// Ports:   period_i  in  CNT_W  measured period in clock cycles
//          note_o    out 4      note index 0..7, or NOTE_NONE
module tone_detector_note_classifier
  import tone_detector_pkg::*;
#(
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned NOTE_SHIFT = 0
) (
  input  logic [CNT_W-1:0] period_i,
  output logic [3:0]       note_o
);

  always_comb begin
    note_o = NOTE_NONE;
    // Windows are disjoint, so at most one index can match.
    for (int i = 0; i < 8; i++) begin
      if (note_match(32'(period_i), note_nom(3'(i)) >> NOTE_SHIFT)) begin
        note_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/tone_detector.sv
// rtl/tone_detector.sv - square-wave tone period meter and note classifier
// Purpose: synchronises a 1-bit audio input, measures the rise-to-rise period,
//          flags tone present/absent and classifies the period as C4..C5.
//          Optional macro TONE_DET_AVG_EN: publish the mean of the last four
//          accepted periods, only once four have been collected since IDLE.
// Ports:   iCLK     in   1      system clock (50 MHz nominal)
//          iRST_N   in   1      asynchronous reset, active low
//          iSOUND   in   1      asynchronous square-wave input
//          oPERIOD  out  CNT_W  last published period in iCLK cycles (0 when silent)
//          oNEW     out  1      one-cycle pulse when oPERIOD/oNOTE update
//          oVALID   out  1      tone present
//          oNOTE    out  4      0..7 = C4..C5, 4'hF = unknown/none
// NOTE_SHIFT scales the nominal note table for a clock 2^NOTE_SHIFT slower than 50 MHz.
module tone_detector
  import tone_detector_pkg::*;
#(
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned MIN_PERIOD  = 1000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned NOTE_SHIFT  = 0
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iSOUND,
  output logic [CNT_W-1:0] oPERIOD,
  output logic             oNEW,
  output logic             oVALID,
  output logic [3:0]       oNOTE
);

  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // sync_q[0], sync_q[1] form the synchroniser; sync_q[2] is the edge-detect delay.
  logic [2:0]       sync_q;
  logic             rise;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] period_q, period_d;
  logic             new_q, new_d;
  logic             valid_q, valid_d;
  logic [3:0]       note_q, note_d;
  logic [CNT_W-1:0] meas;
  logic [3:0]       meas_note;
  logic             publish_ok;

  assign rise = sync_q[1] & ~sync_q[2];

`ifdef TONE_DET_AVG_EN
  // Window = incoming period plus the three accepted before it (hist_q[0] newest).
  logic [2:0][CNT_W-1:0] hist_q, hist_d;
  logic [1:0]            fill_q, fill_d;
  logic [CNT_W+1:0]      sum;

  assign sum        = {2'b00, cnt_q} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
  assign meas       = CNT_W'(sum >> 2);
  assign publish_ok = (fill_q == 2'd3);
`else
  assign meas       = cnt_q;
  assign publish_ok = 1'b1;
`endif

  tone_detector_note_classifier #(
    .CNT_W      (CNT_W),
    .NOTE_SHIFT (NOTE_SHIFT)
  ) u_classifier (
    .period_i (meas),
    .note_o   (meas_note)
  );

  always_comb begin
    cnt_inc  = (cnt_q == CNT_TMO) ? cnt_q : cnt_q + CNT_ONE;
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    new_d    = 1'b0;
    valid_d  = valid_q;
    note_d   = note_q;
`ifdef TONE_DET_AVG_EN
    hist_d   = hist_q;
    fill_d   = fill_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = ST_MEASURE;
          cnt_d   = CNT_ONE;
        end
      end
      default: begin
        // A rise arriving exactly at the timeout count is still a valid period.
        if (rise && (cnt_q >= CNT_MIN)) begin
          cnt_d = CNT_ONE;
          if (publish_ok) begin
            period_d = meas;
            note_d   = meas_note;
            valid_d  = 1'b1;
            new_d    = 1'b1;
          end
`ifdef TONE_DET_AVG_EN
          hist_d = {hist_q[1:0], cnt_q};
          fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
`endif
        end else if (!rise && (cnt_q == CNT_TMO)) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          valid_d  = 1'b0;
          period_d = '0;
          note_d   = NOTE_NONE;
`ifdef TONE_DET_AVG_EN
          hist_d   = '0;
          fill_d   = '0;
`endif
        end else begin
          // Glitch rises fall through here: the running count is not disturbed.
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync_q   <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      new_q    <= 1'b0;
      valid_q  <= 1'b0;
      note_q   <= NOTE_NONE;
`ifdef TONE_DET_AVG_EN
      hist_q   <= '0;
      fill_q   <= '0;
`endif
    end else begin
      sync_q   <= {sync_q[1:0], iSOUND};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      new_q    <= new_d;
      valid_q  <= valid_d;
      note_q   <= note_d;
`ifdef TONE_DET_AVG_EN
      hist_q   <= hist_d;
      fill_q   <= fill_d;
`endif
    end
  end

  assign oPERIOD = period_q;
  assign oNEW    = new_q;
  assign oVALID  = valid_q;
  assign oNOTE   = note_q;

endmodule

// File: tb/tb_tone_detector.sv
// tb/tb_tone_detector.sv - self-checking bench for tone_detector
module tb_tone_detector;

  localparam int MIN = 50;
  localparam int TMO = 2000;
  localparam int SH  = 7;
`ifdef TONE_DET_AVG_EN
  localparam int NR  = 5;
`else
  localparam int NR  = 2;
`endif

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b1;
  logic        iSOUND = 1'b0;
  logic [19:0] oPERIOD;
  logic        oNEW;
  logic        oVALID;
  logic [3:0]  oNOTE;

  int checks = 0;
  int failures = 0;

  tone_detector #(
    .CNT_W       (20),
    .MIN_PERIOD  (MIN),
    .TIMEOUT_CYC (TMO),
    .NOTE_SHIFT  (SH)
  ) dut (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .iSOUND  (iSOUND),
    .oPERIOD (oPERIOD),
    .oNEW    (oNEW),
    .oVALID  (oVALID),
    .oNOTE   (oNOTE)
  );

  always #5 iCLK = ~iCLK;

  int nom50[8] = '{191113, 170265, 151686, 143173, 127551, 113636, 101238, 95556};

  function automatic int ref_note(input int p);
    for (int i = 0; i < 8; i++) begin
      int nom, d;
      nom = nom50[i] / (1 << SH);
      d = p - nom;
      if (d < 0) d = -d;
      if (d <= nom / 64) return i;
    end
    return 15;
  endfunction

  // Reference model: decides from the rules (2-cycle synchroniser delay, period =
  // spacing of rise decisions, glitch rejection, timeout) what the outputs must be.
  int   cyc = 0;
  bit   act = 0;
  int   last = 0;
  bit   m_new = 0, m_valid = 0;
  int   m_period = 0, m_note = 15;
  bit [2:0] hs = '0;
  int   avgq[$];

  task automatic publish(input int v);
    m_period = v; m_note = ref_note(v); m_valid = 1; m_new = 1;
  endtask

  task automatic accept(input int p);
`ifdef TONE_DET_AVG_EN
    int s;
    avgq.push_back(p);
    if (avgq.size() > 4) void'(avgq.pop_front());
    if (avgq.size() == 4) begin
      s = avgq[0] + avgq[1] + avgq[2] + avgq[3];
      publish(s / 4);
    end
`else
    publish(p);
`endif
  endtask

  initial begin
    forever begin
      bit rise;
      @(posedge iCLK);
      cyc++;
      if (!iRST_N) begin
        act = 0; m_new = 0; m_valid = 0; m_period = 0; m_note = 15; hs = '0;
        avgq.delete();
      end else begin
        rise = hs[1] && !hs[2];
        hs = {hs[1:0], iSOUND};
        m_new = 0;
        if (!act) begin
          if (rise) begin act = 1; last = cyc; end
        end else if (rise && (cyc - last) >= MIN) begin
          accept(cyc - last);
          last = cyc;
        end else if (!rise && (cyc - last) == TMO) begin
          act = 0; m_valid = 0; m_period = 0; m_note = 15;
          avgq.delete();
        end
      end
    end
  end

  // Per-cycle compare against the model; stops comparing after the first miss.
  int negcnt = 0, new_cnt = 0, last_new_neg = 0;
  bit mon_dead = 0;
  initial begin
    forever begin
      @(negedge iCLK);
      negcnt++;
      if (oNEW === 1'b1) begin new_cnt++; last_new_neg = negcnt; end
      if (!mon_dead) begin
        checks++;
        if (oNEW !== m_new || oVALID !== m_valid || oPERIOD !== 20'(m_period) || oNOTE !== 4'(m_note)) begin
          failures++;
          mon_dead = 1;
          $display("FAIL model cyc=%0d got new=%0b valid=%0b period=%0d note=%0h exp new=%0b valid=%0b period=%0d note=%0h",
                   cyc, oNEW, oVALID, oPERIOD, oNOTE, m_new, m_valid, m_period, m_note);
        end
      end
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic tick(input bit lvl);
    @(negedge iCLK);
    #1;
    iSOUND = lvl;
  endtask

  task automatic tone(input int p, input int n, input bit gl);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < p; j++) begin
        bit lvl;
        lvl = (j < p / 2);
        if (gl && (j == 20 || j == 21)) lvl = 0;
        tick(lvl);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge iCLK);
    #1;
    iRST_N = 0;
    iSOUND = 0;
    repeat (3) @(negedge iCLK);
    #1;
    iRST_N = 1;
  endtask

  typedef struct {
    int p;
    int n;
    bit v;
    int per;
    int note;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int n0, lat, dt, p, nn, idx, nom, tol;
    bit gl;

    tbl[0]  = '{888,  NR, 1, 888,  5};
    tbl[1]  = '{900,  NR, 1, 900,  5};
    tbl[2]  = '{901,  NR, 1, 901,  15};
    tbl[3]  = '{874,  NR, 1, 874,  5};
    tbl[4]  = '{873,  NR, 1, 873,  15};
    tbl[5]  = '{1493, NR, 1, 1493, 0};
    tbl[6]  = '{735,  NR, 1, 735,  7};
    tbl[7]  = '{940,  NR, 1, 940,  15};
    tbl[8]  = '{50,   NR, 1, 50,   15};
    tbl[9]  = '{49,   2,  0, 0,    15};
    tbl[10] = '{2000, NR, 1, 2000, 15};
    tbl[11] = '{2001, NR, 0, 0,    15};
    tbl[12] = '{996,  NR, 1, 996,  4};

    #1 iRST_N = 0;
    do_reset();
    chk("reset_period", 32'(oPERIOD), 0);
    chk("reset_valid", 32'(oVALID), 0);
    chk("reset_new", 32'(oNEW), 0);
    chk("reset_note", 32'(oNOTE), 15);

    for (int t = 0; t < 13; t++) begin
      do_reset();
      tone(tbl[t].p, tbl[t].n, 1'b0);
      chk($sformatf("tbl%0d_valid", t), 32'(oVALID), 32'(tbl[t].v));
      chk($sformatf("tbl%0d_period", t), 32'(oPERIOD), 32'(tbl[t].per));
      chk($sformatf("tbl%0d_note", t), 32'(oNOTE), 32'(tbl[t].note));
    end

    // Latency: input rise to oNEW pulse.
    do_reset();
    tone(888, NR - 1, 1'b0);
    @(negedge iCLK);
    #1;
    iSOUND = 1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge iCLK);
      #2;
      if (oNEW === 1'b1) begin lat = k; break; end
    end
    chk("latency", 32'(lat), 3);
    chk("latency_period", 32'(oPERIOD), 888);
    repeat (400) tick(1);
    repeat (444) tick(0);

    // Spikes shortly after every rise must be ignored.
    do_reset();
    n0 = new_cnt;
    tone(1493, NR, 1'b1);
    chk("glitch_period", 32'(oPERIOD), 1493);
    chk("glitch_note", 32'(oNOTE), 0);
    chk("glitch_new_count", 32'(new_cnt - n0), 1);

    // Silence: oVALID drops exactly TMO cycles after the last oNEW, with no pulse.
    do_reset();
    tone(888, NR, 1'b0);
    n0 = new_cnt;
    dt = -1;
    for (int k = 0; k < 3 * TMO; k++) begin
      @(negedge iCLK);
      #2;
      if (oVALID !== 1'b1) begin dt = negcnt - last_new_neg; break; end
    end
    chk("timeout_delay", 32'(dt), TMO);
    chk("timeout_no_new", 32'(new_cnt - n0), 0);
    chk("timeout_period", 32'(oPERIOD), 0);
    chk("timeout_note", 32'(oNOTE), 15);

    // Reset mid-tone: immediate clear, then oVALID needs a fresh full period.
    do_reset();
    tone(888, NR, 1'b0);
    chk("pre_reset_valid", 32'(oVALID), 1);
    repeat (100) tick(1);
    @(negedge iCLK);
    #1;
    iRST_N = 0;
    #1;
    chk("async_period", 32'(oPERIOD), 0);
    chk("async_valid", 32'(oVALID), 0);
    chk("async_note", 32'(oNOTE), 15);
    repeat (3) @(negedge iCLK);
    #1;
    iRST_N = 1;
    iSOUND = 0;
    tone(888, NR - 1, 1'b0);
    chk("restart_valid_early", 32'(oVALID), 0);
    tone(888, 1, 1'b0);
    chk("restart_valid", 32'(oVALID), 1);
    chk("restart_note", 32'(oNOTE), 5);

    // Averaging sequence around A4.
    do_reset();
    n0 = new_cnt;
    tone(886, 1, 1'b0);
    tone(889, 1, 1'b0);
    tone(886, 1, 1'b0);
`ifdef TONE_DET_AVG_EN
    chk("avg_mid_period", 32'(oPERIOD), 0);
`else
    chk("avg_mid_period", 32'(oPERIOD), 889);
`endif
    tone(889, 1, 1'b0);
    tone(888, 1, 1'b0);
`ifdef TONE_DET_AVG_EN
    chk("avg_period", 32'(oPERIOD), 887);
    chk("avg_new_count", 32'(new_cnt - n0), 1);
`else
    chk("avg_period", 32'(oPERIOD), 889);
    chk("avg_new_count", 32'(new_cnt - n0), 4);
`endif
    chk("avg_note", 32'(oNOTE), 5);

    // Randomized segments; the per-cycle model compare does the checking.
    do_reset();
    for (int s = 0; s < 6; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        p = int'($urandom_range(40, 2100));
      end else begin
        idx = int'($urandom_range(0, 7));
        nom = nom50[idx] / (1 << SH);
        tol = nom / 64;
        p = nom - tol - 2 + int'($urandom_range(0, 2 * tol + 4));
      end
      nn = int'($urandom_range(1, 2));
      gl = (p >= 60) && ($urandom_range(0, 1) == 1);
      tone(p, nn, gl);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 1500)) tick(0);
    end
    repeat (20) tick(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
